// File: rtl/param_qcount_disp.sv
// ---------------------------------------------------------------------------
// param_qcount_disp
//   Parameterised up/down counter with load, wrap/saturate boundary handling,
//   a one-cycle terminal-count pulse, a sticky boundary flag and an
//   active-low seven-segment decode of every nibble of the count.
//
//   Optional feature macro: QCOUNT_BCD_EN
//     undefined : plain binary count, displays 0-F
//     defined   : packed-BCD count (each nibble 0..9), displays 0-9 only
//
// Parameters
//   WIDTH  counter width, multiple of 4 in 4..16 (DIGITS = WIDTH/4)
//   MAXV   terminal count value, 1 .. 2^WIDTH-1
//
// Ports
//   clk     in   rising-edge clock
//   clr     in   synchronous active-high reset (q, tc, ovf -> 0)
//   en      in   count enable, one step per enabled edge
//   up      in   1 = increment, 0 = decrement
//   sat     in   1 = saturate at the boundary, 0 = wrap
//   load    in   parallel load strobe (beats en)
//   ld_val  in   value captured on load, clamped to the terminal count
//   q       out  registered count
//   tc      out  registered pulse after a step taken from a boundary
//   ovf     out  sticky boundary flag, cleared only by clr
//   hex     out  7*DIGITS active-low segments, hex[7k+6:7k] = nibble k
// ---------------------------------------------------------------------------
module param_qcount_disp #(
    parameter int          WIDTH = 8,
    parameter int unsigned MAXV  = (2 ** WIDTH) - 1
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       en,
    input  logic                       up,
    input  logic                       sat,
    input  logic                       load,
    input  logic [WIDTH-1:0]           ld_val,
    output logic [WIDTH-1:0]           q,
    output logic                       tc,
    output logic                       ovf,
    output logic [7*(WIDTH/4)-1:0]     hex
);

    localparam int               DIGITS = WIDTH / 4;
    localparam logic [WIDTH-1:0] MAXV_W = WIDTH'(MAXV);

`ifdef QCOUNT_BCD_EN
    // Largest valid BCD value not above v: the first nibble (from the top)
    // that is not a decimal digit becomes 9, and so does everything below it.
    function automatic logic [WIDTH-1:0] bcd_floor(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             force9;
        r      = v;
        force9 = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (force9 || (r[4*k +: 4] > 4'd9)) begin
                r[4*k +: 4] = 4'd9;
                force9      = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [WIDTH-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             c;
        r = v;
        c = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (c) begin
                if (r[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = r[4*k +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] step_dn(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             b;
        r = v;
        b = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (b) begin
                if (r[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = r[4*k +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [WIDTH-1:0] EFF_MAX = bcd_floor(MAXV_W);
`else
    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
        return v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] step_dn(input logic [WIDTH-1:0] v);
        return v - WIDTH'(1);
    endfunction

    localparam logic [WIDTH-1:0] EFF_MAX = MAXV_W;
`endif

    // Segment pattern, bit 0 = a .. bit 6 = g, lit = 0.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             ld_ok;

`ifdef QCOUNT_BCD_EN
    assign ld_ok = (ld_val <= EFF_MAX) && bcd_valid(ld_val);
`else
    assign ld_ok = (ld_val <= EFF_MAX);
`endif

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (load) begin
            cnt_d = ld_ok ? ld_val : EFF_MAX;
        end else if (en) begin
            if (up) begin
                if (cnt_q == EFF_MAX) begin
                    tc_d  = 1'b1;
                    cnt_d = sat ? EFF_MAX : '0;
                end else begin
                    cnt_d = step_up(cnt_q);
                end
            end else begin
                if (cnt_q == '0) begin
                    tc_d  = 1'b1;
                    cnt_d = sat ? '0 : EFF_MAX;
                end else begin
                    cnt_d = step_dn(cnt_q);
                end
            end
        end
        ovf_d = ovf_q | tc_d;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

    for (genvar k = 0; k < DIGITS; k++) begin : g_hex
        assign hex[7*k +: 7] = seg7(cnt_q[4*k +: 4]);
    end

endmodule
